int_arbiter: RTL and testbench

INT_ARBITER -- requirements
Module: int_arbiter

---
 rtl/int_arbiter_pkg.sv | 24 ++
 rtl/irq_sync_edge.sv | 31 +++
 rtl/int_arbiter.sv | 110 +++++++++++
 tb/tb_int_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/int_arbiter_pkg.sv
// rtl/int_arbiter_pkg.sv - shared types, constants and priority helper for int_arbiter
package int_arbiter_pkg;

  localparam int          NUM_SRC        = 4;
  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'd16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Lowest set index wins; returns 0 for an empty vector.
  function automatic logic [1:0] prio_id(input logic [NUM_SRC-1:0] v);
    logic [1:0] id;
    id = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) id = 2'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchronizer plus rising-edge detector for one IRQ line
module irq_sync_edge (
  input  logic in_CLK,
  input  logic in_RST,
  input  logic irq,
  output logic rise
);

  logic       sync_1;
  logic       sync_2;
  logic       prev;
  logic [1:0] arm_cnt;

  // arm_cnt holds off detection until prev has caught up with a line already high at reset release.
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      prev    <= 1'b0;
      arm_cnt <= 2'd0;
    end else begin
      sync_1 <= irq;
      sync_2 <= sync_1;
      prev   <= sync_2;
      if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  assign rise = sync_2 & ~prev & (arm_cnt == 2'd3);

endmodule

// File: rtl/int_arbiter.sv
// rtl/int_arbiter.sv - 4-source prioritised interrupt arbiter; nesting enabled by INT_ARBITER_NEST_EN
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic        in_CLK,
  input  logic        in_RST,
  input  logic [3:0]  in_IRQ,
  input  logic        in_IE,
  input  logic [3:0]  in_INM,
  input  logic        in_ACK,
  input  logic        in_ERET,
  output logic        out_REQ,
  output logic        out_BK,
  output logic        out_NIE,
  output logic [31:0] out_VEC,
  output logic [1:0]  out_ID,
  output logic [3:0]  out_PEND,
  output logic [3:0]  out_ISR
);

  state_t     state;
  logic [3:0] pending;
  logic [3:0] isr;
  logic [3:0] rise;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .in_CLK (in_CLK),
      .in_RST (in_RST),
      .irq    (in_IRQ[g]),
      .rise   (rise[g])
    );
  end

  logic [3:0] eligible;
  logic       any_elig;
  logic [1:0] sel_id;
  logic [3:0] sel_mask;
  logic [1:0] top_isr;
  logic [3:0] eret_mask;
  logic       preempt_ok;
  logic       can_req;
  logic       accept;
  logic       start_idle;

  assign eligible  = pending & ~in_INM;
  assign any_elig  = |eligible;
  assign sel_id    = prio_id(eligible);
  assign sel_mask  = 4'b0001 << sel_id;
  assign top_isr   = prio_id(isr);
  assign eret_mask = (isr == 4'd0) ? 4'd0 : (4'b0001 << top_isr);

`ifdef INT_ARBITER_NEST_EN
  assign preempt_ok = (isr == 4'd0) || (sel_id < top_isr);
`else
  assign preempt_ok = (isr == 4'd0);
`endif

  assign can_req    = in_IE & any_elig & preempt_ok;
  assign accept     = (state == REQ) & in_ACK & any_elig;
  // Idle also looks at this cycle's edges so a fresh line reaches REQ together with its pending bit.
  assign start_idle = in_IE & (|((pending | rise) & ~in_INM));

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      state   <= IDLE;
      pending <= 4'd0;
      isr     <= 4'd0;
    end else begin
      pending <= (pending & ~(accept ? sel_mask : 4'd0)) | rise;
      case (state)
        IDLE: begin
          if (start_idle) state <= REQ;
        end
        REQ: begin
          if (accept) begin
            isr   <= isr | sel_mask;
            state <= SERVICE;
          end else if (!can_req) begin
            state <= (isr != 4'd0) ? SERVICE : IDLE;
          end
        end
        SERVICE: begin
          if (in_ERET && (isr != 4'd0)) begin
            isr <= isr & ~eret_mask;
            if ((isr & ~eret_mask) == 4'd0) state <= IDLE;
          end
`ifdef INT_ARBITER_NEST_EN
          else if (can_req) begin
            state <= REQ;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_REQ  = (state == REQ);
  assign out_BK   = accept;
  assign out_NIE  = 1'b0;
  assign out_ID   = sel_id;
  assign out_VEC  = VEC_BASE + ({30'd0, sel_id} * VEC_STRIDE);
  assign out_PEND = pending;
  assign out_ISR  = isr;

endmodule

// File: tb/tb_int_arbiter.sv
// tb/tb_int_arbiter.sv - scoreboard bench for int_arbiter
module tb_int_arbiter;

  logic        in_CLK = 1'b0;
  logic        in_RST = 1'b1;
  logic [3:0]  in_IRQ = 4'd0;
  logic        in_IE = 1'b1;
  logic [3:0]  in_INM = 4'd0;
  logic        in_ACK = 1'b0;
  logic        in_ERET = 1'b0;
  logic        out_REQ;
  logic        out_BK;
  logic        out_NIE;
  logic [31:0] out_VEC;
  logic [1:0]  out_ID;
  logic [3:0]  out_PEND;
  logic [3:0]  out_ISR;

  int_arbiter dut (
    .in_CLK   (in_CLK),
    .in_RST   (in_RST),
    .in_IRQ   (in_IRQ),
    .in_IE    (in_IE),
    .in_INM   (in_INM),
    .in_ACK   (in_ACK),
    .in_ERET  (in_ERET),
    .out_REQ  (out_REQ),
    .out_BK   (out_BK),
    .out_NIE  (out_NIE),
    .out_VEC  (out_VEC),
    .out_ID   (out_ID),
    .out_PEND (out_PEND),
    .out_ISR  (out_ISR)
  );

  always #5 in_CLK = ~in_CLK;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  // Accept monitor: every break pulse must match the next expected accept.
  always @(negedge in_CLK) begin
    if (!in_RST && out_BK) begin
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected_bk: got id %0d with empty queue", out_ID);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (out_ID !== e.id || out_VEC !== e.vec)
          $display("FAIL sb_accept: got id %0d vec %h expected id %0d vec %h", out_ID, out_VEC, e.id, e.vec);
        else n_pass++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge in_CLK);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!out_REQ && n < 3) begin
      step(1);
      n++;
    end
    chk(name, {31'd0, out_REQ}, 32'd1);
  endtask

  task automatic accept(input logic [1:0] id, input logic [31:0] vec);
    exp_t e;
    e.id  = id;
    e.vec = vec;
    sb_q.push_back(e);
    in_ACK = 1'b1;
    #1;
    chk("bk_on_ack", {31'd0, out_BK}, 32'd1);
    step(1);
    in_ACK = 1'b0;
  endtask

  task automatic eret();
    in_ERET = 1'b1;
    step(1);
    in_ERET = 1'b0;
  endtask

  initial begin
    step(2);
    chk("rst_req",  {31'd0, out_REQ}, 32'd0);
    chk("rst_bk",   {31'd0, out_BK},  32'd0);
    chk("rst_pend", {28'd0, out_PEND}, 32'd0);
    chk("rst_isr",  {28'd0, out_ISR},  32'd0);
    chk("rst_id",   {30'd0, out_ID},   32'd0);
    chk("nie",      {31'd0, out_NIE},  32'd0);
    in_RST = 1'b0;
    step(4);

    // basic accept of source 2
    in_IRQ[2] = 1'b1;
    wait_req("basic_req");
    chk("basic_id",  {30'd0, out_ID}, 32'd2);
    chk("basic_vec", out_VEC, 32'h120);
    accept(2'd2, 32'h120);
    in_IRQ[2] = 1'b0;
    chk("basic_isr",  {28'd0, out_ISR},  32'h4);
    chk("basic_pend", {28'd0, out_PEND}, 32'h0);
    chk("basic_req_off", {31'd0, out_REQ}, 32'd0);

    in_ACK = 1'b1;
    #1;
    chk("ack_in_service_bk", {31'd0, out_BK}, 32'd0);
    step(1);
    in_ACK = 1'b0;
    chk("ack_in_service_isr", {28'd0, out_ISR}, 32'h4);

    // nesting: source 0 rises while source 2 is in service
    in_IRQ[0] = 1'b1;
    step(4);
    in_IRQ[0] = 1'b0;
    chk("nest_pend", {28'd0, out_PEND}, 32'h1);
`ifdef INT_ARBITER_NEST_EN
    chk("nest_req", {31'd0, out_REQ}, 32'd1);
    chk("nest_id",  {30'd0, out_ID},  32'd0);
    accept(2'd0, 32'h100);
    chk("nest_isr", {28'd0, out_ISR}, 32'h5);
    eret();
    chk("nest_eret1", {28'd0, out_ISR}, 32'h4);
    eret();
    chk("nest_eret2", {28'd0, out_ISR}, 32'h0);
`else
    chk("nonest_req", {31'd0, out_REQ}, 32'd0);
    chk("nonest_isr", {28'd0, out_ISR}, 32'h4);
    eret();
    chk("nonest_eret", {28'd0, out_ISR}, 32'h0);
    wait_req("nonest_req_after_eret");
    chk("nonest_id", {30'd0, out_ID}, 32'd0);
    accept(2'd0, 32'h100);
    chk("nonest_isr0", {28'd0, out_ISR}, 32'h1);
    eret();
`endif
    chk("eret_empty", {28'd0, out_ISR}, 32'h0);

    // priority: 3 and 1 together
    in_IRQ = 4'b1010;
    wait_req("prio_req");
    chk("prio_id1",  {30'd0, out_ID}, 32'd1);
    chk("prio_vec1", out_VEC, 32'h110);
    accept(2'd1, 32'h110);
    in_IRQ = 4'd0;
    chk("prio_isr",  {28'd0, out_ISR},  32'h2);
    chk("prio_pend", {28'd0, out_PEND}, 32'h8);
    eret();
    wait_req("prio_req3");
    chk("prio_id3",  {30'd0, out_ID}, 32'd3);
    chk("prio_vec3", out_VEC, 32'h130);
    accept(2'd3, 32'h130);
    eret();

    // masking keeps the pending bit visible
    in_INM = 4'b0001;
    in_IRQ[0] = 1'b1;
    step(4);
    in_IRQ[0] = 1'b0;
    chk("mask_pend", {28'd0, out_PEND}, 32'h1);
    chk("mask_req",  {31'd0, out_REQ},  32'd0);
    in_INM = 4'd0;
    wait_req("unmask_req");
    chk("unmask_id", {30'd0, out_ID}, 32'd0);
    accept(2'd0, 32'h100);
    eret();

    // withdrawal when IE drops in REQ
    in_IRQ[1] = 1'b1;
    wait_req("wd_req");
    in_IE = 1'b0;
    step(1);
    chk("wd_req_off", {31'd0, out_REQ},  32'd0);
    chk("wd_pend",    {28'd0, out_PEND}, 32'h2);
    chk("wd_isr",     {28'd0, out_ISR},  32'h0);
    step(2);
    chk("wd_idle", {31'd0, out_REQ}, 32'd0);
    in_IE = 1'b1;
    wait_req("wd_rereq");
    chk("wd_id", {30'd0, out_ID}, 32'd1);
    accept(2'd1, 32'h110);
    eret();
    in_IRQ = 4'd0;

    // reset during REQ, line held high across release
    in_IRQ[3] = 1'b1;
    wait_req("rst_mid_req");
    in_RST = 1'b1;
    #1;
    chk("rst_mid_req_off", {31'd0, out_REQ},  32'd0);
    chk("rst_mid_bk",      {31'd0, out_BK},   32'd0);
    chk("rst_mid_pend",    {28'd0, out_PEND}, 32'h0);
    chk("rst_mid_isr",     {28'd0, out_ISR},  32'h0);
    chk("rst_mid_id",      {30'd0, out_ID},   32'd0);
    step(2);
    in_RST = 1'b0;
    step(6);
    chk("rel_high_req",  {31'd0, out_REQ},  32'd0);
    chk("rel_high_pend", {28'd0, out_PEND}, 32'h0);
    in_IRQ = 4'd0;
    step(2);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
